complex_multiplier_pipe: RTL and testbench

- Parametrised, fully pipelined complex multiplier for FFT butterflies: data sample × twiddle, optional per-sample conjugation of the twiddle for IFFT passes.
- Generalised width and fraction, a valid/ready handshake with backpressure, single-point rounding and saturating output with a sticky overflow flag.
- Sits between the twiddle ROM / data memory read path and the butterfly adder stage.

---
 rtl/complex_multiplier_pipe_if.sv | 33 +++
 rtl/complex_multiplier_pipe.sv | 153 +++++++++++++++
 tb/tb_complex_multiplier_pipe.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/complex_multiplier_pipe_if.sv
// Streaming interface of complex_multiplier_pipe: input sample/twiddle with a
// valid/ready handshake, output product with valid/ready, plus the sticky
// overflow clear/flag pair.
interface complex_multiplier_pipe_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TW_W   = 16
);
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_data_re;
    logic [DATA_W-1:0] i_data_im;
    logic [TW_W-1:0]   i_tw_re;
    logic [TW_W-1:0]   i_tw_im;
    logic              i_conj;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_prod_re;
    logic [DATA_W-1:0] o_prod_im;
    logic              i_clr_ovf;
    logic              o_ovf;

    // Multiplier side
    modport slave (
        input  i_valid, i_data_re, i_data_im, i_tw_re, i_tw_im, i_conj, i_ready, i_clr_ovf,
        output o_ready, o_valid, o_prod_re, o_prod_im, o_ovf
    );

    // Producer/consumer side
    modport master (
        output i_valid, i_data_re, i_data_im, i_tw_re, i_tw_im, i_conj, i_ready, i_clr_ovf,
        input  o_ready, o_valid, o_prod_re, o_prod_im, o_ovf
    );
endinterface

// File: rtl/complex_multiplier_pipe.sv
// Three-stage pipelined complex multiplier (data x twiddle, optional twiddle
// conjugation) with a global-stall valid/ready handshake, a single rounding
// point and a sticky overflow flag.
// Build option: define CMULT_SATURATE_EN to clip out-of-range results; without
// it the output wraps to the low DATA_W bits while o_ovf still flags the range
// violation.
module complex_multiplier_pipe #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TW_W   = 16,
    parameter int unsigned TW_F   = TW_W - 1
) (
    input logic                     i_clk,
    input logic                     i_rst,
    complex_multiplier_pipe_if.slave bus
);
    localparam int unsigned PW = DATA_W + TW_W;   // product width
    localparam int unsigned SW = PW + 1;          // combined sum width
    localparam int unsigned XW = SW + 1 - TW_F;   // rounded, shifted width

    // Half an LSB of the output, added once before the shift (round-half-up)
    localparam logic signed [SW:0] Rnd = {{SW{1'b0}}, 1'b1} << (TW_F - 1);

`ifdef CMULT_SATURATE_EN
    localparam logic [DATA_W-1:0] PosMax = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0] NegMax = {1'b1, {(DATA_W - 1){1'b0}}};
`endif

    logic adv;

    logic v1_q, v2_q, v3_q;
    logic conj_q;
    logic signed [PW-1:0] a_x, b_x, c_x, d_x;
    logic signed [PW-1:0] ac_d, ad_d, bc_d, bd_d;
    logic signed [PW-1:0] ac_q, ad_q, bc_q, bd_q;
    logic signed [SW-1:0] re_s_d, im_s_d, re_s_q, im_s_q;
    logic signed [SW:0]   re_rnd, im_rnd;
    logic [XW-1:0]        re_x, im_x;
    logic                 re_oor, im_oor;
    logic [DATA_W-1:0]    re_d, im_d, re_q, im_q;
    logic                 ovf_d, ovf_q;
    logic                 unused_rnd;

    // Global stall: every stage moves only when the output slot is free or drained
    always_comb begin
        adv         = !v3_q || bus.i_ready;
        bus.o_ready = adv && !i_rst;
        bus.o_valid = v3_q;
        bus.o_prod_re = re_q;
        bus.o_prod_im = im_q;
        bus.o_ovf   = ovf_q;
    end

    // S1 next state: four partial products on sign-extended operands
    always_comb begin
        a_x  = {{TW_W{bus.i_data_re[DATA_W-1]}}, bus.i_data_re};
        b_x  = {{TW_W{bus.i_data_im[DATA_W-1]}}, bus.i_data_im};
        c_x  = {{DATA_W{bus.i_tw_re[TW_W-1]}}, bus.i_tw_re};
        d_x  = {{DATA_W{bus.i_tw_im[TW_W-1]}}, bus.i_tw_im};
        ac_d = a_x * c_x;
        ad_d = a_x * d_x;
        bc_d = b_x * c_x;
        bd_d = b_x * d_x;
    end

    // S1 register: products captured on an accepted input
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v1_q   <= 1'b0;
            conj_q <= 1'b0;
            ac_q   <= '0;
            ad_q   <= '0;
            bc_q   <= '0;
            bd_q   <= '0;
        end else if (adv) begin
            v1_q <= bus.i_valid;
            if (bus.i_valid) begin
                conj_q <= bus.i_conj;
                ac_q   <= ac_d;
                ad_q   <= ad_d;
                bc_q   <= bc_d;
                bd_q   <= bd_d;
            end
        end
    end

    // S2 next state: full-precision combine, conj flips the sign of d
    always_comb begin
        re_s_d = '0;
        im_s_d = '0;
        if (conj_q) begin
            re_s_d = {ac_q[PW-1], ac_q} + {bd_q[PW-1], bd_q};
            im_s_d = {bc_q[PW-1], bc_q} - {ad_q[PW-1], ad_q};
        end else begin
            re_s_d = {ac_q[PW-1], ac_q} - {bd_q[PW-1], bd_q};
            im_s_d = {ad_q[PW-1], ad_q} + {bc_q[PW-1], bc_q};
        end
    end

    // S2 register: combined sums
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v2_q   <= 1'b0;
            re_s_q <= '0;
            im_s_q <= '0;
        end else if (adv) begin
            v2_q <= v1_q;
            if (v1_q) begin
                re_s_q <= re_s_d;
                im_s_q <= im_s_d;
            end
        end
    end

    // S3 next state: round once, range check, then clip or wrap
    always_comb begin
        re_rnd     = {re_s_q[SW-1], re_s_q} + Rnd;
        im_rnd     = {im_s_q[SW-1], im_s_q} + Rnd;
        re_x       = re_rnd[SW:TW_F];
        im_x       = im_rnd[SW:TW_F];
        unused_rnd = ^{re_rnd[TW_F-1:0], im_rnd[TW_F-1:0]};
        // In range iff every bit above the output sign bit matches it
        re_oor     = !((&re_x[XW-1:DATA_W-1]) || !(|re_x[XW-1:DATA_W-1]));
        im_oor     = !((&im_x[XW-1:DATA_W-1]) || !(|im_x[XW-1:DATA_W-1]));
`ifdef CMULT_SATURATE_EN
        re_d = re_oor ? (re_x[XW-1] ? NegMax : PosMax) : re_x[DATA_W-1:0];
        im_d = im_oor ? (im_x[XW-1] ? NegMax : PosMax) : im_x[DATA_W-1:0];
`else
        re_d = re_x[DATA_W-1:0];
        im_d = im_x[DATA_W-1:0];
`endif
        // A set in the same cycle as a clear must win
        ovf_d = (ovf_q && !bus.i_clr_ovf) || (adv && v2_q && (re_oor || im_oor));
    end

    // S3 register: output sample and sticky overflow
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v3_q  <= 1'b0;
            re_q  <= '0;
            im_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            if (adv) begin
                v3_q <= v2_q;
                if (v2_q) begin
                    re_q <= re_d;
                    im_q <= im_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_complex_multiplier_pipe.sv
// Scoreboard bench for complex_multiplier_pipe: the driver pushes expected
// products when a sample is accepted, the monitor compares at each output.
module tb_complex_multiplier_pipe;
    localparam int DW  = 16;
    localparam int TWW = 16;
    localparam int TWF = 15;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        bit          ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    complex_multiplier_pipe_if #(.DATA_W(DW), .TW_W(TWW)) bus ();

    complex_multiplier_pipe #(.DATA_W(DW), .TW_W(TWW), .TW_F(TWF)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   exp_ovf    = 1'b0;
    bit   front_seen = 1'b0;
    bit   stall   = 1'b0;
    bit   rand_bp = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] fit(input longint x);
        logic [15:0] r;
        r = x[15:0];
`ifdef CMULT_SATURATE_EN
        if (x > 32767) r = 16'h7fff;
        if (x < -32768) r = 16'h8000;
`endif
        return r;
    endfunction

    // Reference: exact complex product, one round-half-up to Q15, then range rule
    function automatic exp_t model(input longint a, input longint b, input longint c,
                                   input longint d, input bit cj);
        exp_t   e;
        longint dd, s_re, s_im, x_re, x_im;
        dd   = cj ? -d : d;
        s_re = a * c - b * dd;
        s_im = a * dd + b * c;
        x_re = (s_re + (longint'(1) <<< (TWF - 1))) >>> TWF;
        x_im = (s_im + (longint'(1) <<< (TWF - 1))) >>> TWF;
        e.re  = fit(x_re);
        e.im  = fit(x_im);
        e.ovf = (x_re > 32767) || (x_re < -32768) || (x_im > 32767) || (x_im < -32768);
        return e;
    endfunction

    function automatic exp_t mk(input int re, input int im, input bit ovf);
        exp_t e;
        e.re  = re[15:0];
        e.im  = im[15:0];
        e.ovf = ovf;
        return e;
    endfunction

    // Present one sample and hold it until the handshake takes it
    task automatic send(input int a, input int b, input int c, input int d, input bit cj,
                        input exp_t e);
        bit acc;
        int n;
        bus.i_valid   = 1'b1;
        bus.i_data_re = a[15:0];
        bus.i_data_im = b[15:0];
        bus.i_tw_re   = c[15:0];
        bus.i_tw_im   = d[15:0];
        bus.i_conj    = cj;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.o_ready;
            @(posedge clk);
            if (acc) exp_q.push_back(e);
            n++;
            #1;
        end
        if (!acc) check("accept_timeout", 0, 1);
        bus.i_valid = 1'b0;
    endtask

    task automatic send_rand();
        int a, b, c, d;
        bit cj;
        a  = int'($urandom_range(0, 65535)) - 32768;
        b  = int'($urandom_range(0, 65535)) - 32768;
        c  = int'($urandom_range(0, 65535)) - 32768;
        d  = int'($urandom_range(0, 65535)) - 32768;
        cj = 1'($urandom_range(0, 1));
        send(a, b, c, d, cj, model(a, b, c, d, cj));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic clr_pulse();
        @(posedge clk);
        #1 bus.i_clr_ovf = 1'b1;
        @(posedge clk);
        #1 bus.i_clr_ovf = 1'b0;
        exp_ovf = 1'b0;
    endtask

    // Check o_valid rises on the third clock edge counting the capture edge
    task automatic latency_probe(input int a, input int b, input int c, input int d,
                                 input bit cj, input exp_t e);
        send(a, b, c, d, cj, e);
        check("latency_o_valid_edge1", bus.o_valid, 0);
        @(posedge clk);
        #1 check("latency_o_valid_edge2", bus.o_valid, 0);
        @(posedge clk);
        #1 check("latency_o_valid_edge3", bus.o_valid, 1);
    endtask

    // Downstream ready: held low on request, else random or always high
    initial begin
        bus.i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall) bus.i_ready = 1'b0;
            else if (rand_bp) bus.i_ready = ($urandom_range(0, 3) != 0);
            else bus.i_ready = 1'b1;
        end
    end

    // Monitor: compares the head of the scoreboard while the output is valid
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("o_ready_rule", bus.o_ready, !bus.o_valid || bus.i_ready);
                if (bus.o_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        if (!front_seen) begin
                            exp_ovf    = exp_ovf | exp_q[0].ovf;
                            front_seen = 1'b1;
                        end
                        check("prod_re", $signed(bus.o_prod_re), $signed(exp_q[0].re));
                        check("prod_im", $signed(bus.o_prod_im), $signed(exp_q[0].im));
                        if (bus.i_ready) begin
                            void'(exp_q.pop_front());
                            front_seen = 1'b0;
                        end
                    end
                end
                check("o_ovf", bus.o_ovf, exp_ovf);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.i_valid   = 1'b0;
        bus.i_data_re = '0;
        bus.i_data_im = '0;
        bus.i_tw_re   = '0;
        bus.i_tw_im   = '0;
        bus.i_conj    = 1'b0;
        bus.i_clr_ovf = 1'b0;
        #12;
        check("reset_o_valid", bus.o_valid, 0);
        check("reset_prod_re", bus.o_prod_re, 0);
        check("reset_prod_im", bus.o_prod_im, 0);
        check("reset_o_ovf", bus.o_ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("idle_o_ready", bus.o_ready, 1);

        // Basic 0.5 * 0.5 with latency probe
        latency_probe(16384, 0, 16384, 0, 1'b0, mk(8192, 0, 1'b0));
        drain();

        // Rounding and conjugation, back to back
        send(1, 0, 16384, 0, 1'b0, mk(1, 0, 1'b0));
        send(-1, 0, 16384, 0, 1'b0, mk(0, 0, 1'b0));
        send(0, 3, 0, 16384, 1'b0, mk(-1, 0, 1'b0));
        send(0, 16384, 0, 16384, 1'b0, mk(-8192, 0, 1'b0));
        send(0, 16384, 0, 16384, 1'b1, mk(8192, 0, 1'b0));
        drain();

        // (-1-i)^2: imag is +2.0; clipped to max, or wrapped to low bits (0)
`ifdef CMULT_SATURATE_EN
        send(-32768, -32768, -32768, -32768, 1'b0, mk(0, 32767, 1'b1));
`else
        send(-32768, -32768, -32768, -32768, 1'b0, mk(0, 0, 1'b1));
`endif
        drain();
        check("sat_ovf_set", bus.o_ovf, 1);
        clr_pulse();
        check("ovf_cleared", bus.o_ovf, 0);

        // Random samples with random gaps and random downstream stalls
        rand_bp = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send_rand();
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        rand_bp = 1'b0;
        clr_pulse();

        // Continuous stream of 8 with a 5-cycle downstream stall in the middle
        fork
            begin
                for (int i = 0; i < 8; i++) send_rand();
            end
            begin
                repeat (4) @(posedge clk);
                stall = 1'b1;
                repeat (5) @(posedge clk);
                stall = 1'b0;
            end
        join
        drain();
        clr_pulse();

        // Asynchronous reset with three samples in flight
        send(-32768, -32768, -32768, -32768, 1'b0, mk(0, 0, 1'b1));
        send(100, 200, 300, 400, 1'b0, model(100, 200, 300, 400, 1'b0));
        send(5, 6, 7, 8, 1'b1, model(5, 6, 7, 8, 1'b1));
        #2;
        check("pre_reset_o_valid", bus.o_valid, 1);
        check("pre_reset_o_ovf", bus.o_ovf, 1);
        rst = 1'b1;
        #1;
        check("async_reset_o_valid", bus.o_valid, 0);
        check("async_reset_prod_re", bus.o_prod_re, 0);
        check("async_reset_prod_im", bus.o_prod_im, 0);
        check("async_reset_o_ovf", bus.o_ovf, 0);
        exp_q.delete();
        front_seen = 1'b0;
        exp_ovf    = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        latency_probe(-12345, 23456, 30000, -20000, 1'b1,
                      model(-12345, 23456, 30000, -20000, 1'b1));
        drain();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
